rf_wb_arbiter: RTL

Write-back arbiter and sequencer for the 32×32 register file write port (`we3`/`a3`/`wd3`). It accepts write requests from two producers, the ALU (port 0) and the load unit (port 1), over valid/ready handshakes. Each cycle it grants at most one request using round-robin priority and drives the register file write port from an output register. It discards writes to x0, supports a pipeline flush, and keeps per-source saturating write counters for performance monitoring.

---
 rtl/rf_wb_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter : round-robin write-back arbiter (ALU/LSU) for the regfile port
// Rev 1.0
// ============================================================================
module rf_wb_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             v0,
   input  logic [4:0]       a0,
   input  logic [31:0]      d0,
   output logic             r0,
   input  logic             v1,
   input  logic [4:0]       a1,
   input  logic [31:0]      d1,
   output logic             r1,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   logic             we_q,    we_d;
   logic [4:0]       waddr_q, waddr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             last_q,  last_d;
   logic [CNT_W-1:0] cnt0_q,  cnt0_d;
   logic [CNT_W-1:0] cnt1_q,  cnt1_d;
   logic             w_xfer0, w_xfer1;

   // Ready is gated by rst_n so nothing is accepted while reset is held.
   always_comb begin
      r0 = 1'b0;
      r1 = 1'b0;
      if (rst_n && !flush) begin
         if (v0 && v1) begin
            r0 = last_q;
            r1 = ~last_q;
         end else if (v0) begin
            r0 = 1'b1;
         end else if (v1) begin
            r1 = 1'b1;
         end
      end
   end

   assign w_xfer0 = v0 & r0;
   assign w_xfer1 = v1 & r1;

   always_comb begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      last_d  = last_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      if (w_xfer0) begin
         we_d    = (a0 != 5'd0);
         waddr_d = a0;
         wdata_d = d0;
         last_d  = 1'b0;
         if ((a0 != 5'd0) && (cnt0_q != C_CNT_MAX)) cnt0_d = cnt0_q + 1'b1;
      end else if (w_xfer1) begin
         we_d    = (a1 != 5'd0);
         waddr_d = a1;
         wdata_d = d1;
         last_d  = 1'b1;
         if ((a1 != 5'd0) && (cnt1_q != C_CNT_MAX)) cnt1_d = cnt1_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         waddr_q <= 5'd0;
         wdata_q <= 32'd0;
         last_q  <= 1'b1;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   assign rf_we    = we_q;
   assign rf_waddr = waddr_q;
   assign rf_wdata = wdata_q;
   assign cnt0     = cnt0_q;
   assign cnt1     = cnt1_q;

endmodule
`default_nettype wire
